ccff_loader: RTL and testbench
==============================

# ccff_loader

Bitstream loader for the configuration-chain (ccff) fabric. It sits directly upstream of the first `ccff_head` in the tile chain. It accepts configuration bytes over a valid/ready handshake, serialises them LSB-first onto the chain, and produces a shift enable for the external prog-clock gate. It stops after exactly `CHAIN_LEN` bits. It also folds every bit emerging from the far end of the chain (`ccff_tail`) into a parity signature, so the previous configuration can be checked during reload.

## Interface
- `CHAIN_LEN`, default 1024: total configuration bits in the chain; ≥1.
- `DATA_W`, default 8: byte width of `data_in`; ≥1.
- `CNT_W`, default `$clog2(CHAIN_LEN+1)`: width of `bits_left`; derived, not overridden.

- `prog_clk`, in, 1: the only clock, free-running. All logic is on its rising edge.
- `prog_reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: single-cycle pulse that begins a load. Ignored while `busy`=1.
- `data_in`, in, `DATA_W`: configuration byte. Bit 0 is shifted first.
- `data_valid`, in, 1: `data_in` is valid.
- `data_ready`, out, 1: loader accepts `data_in` this cycle.
- `ccff_head`, out, 1: serial bit to the chain. Registered.
- `ccff_shift_en`, out, 1: registered enable to the ICG that produces the chain clock. The chain shifts once per cycle in which this is 1.
- `ccff_tail`, in, 1: last bit of the chain.
- `busy`, out, 1: a load is in progress.
- `done`, out, 1: the load completed. Held until the next `start`.
- `bits_left`, out, `CNT_W`: bits still to shift.
- `tail_parity`, out, 1: XOR of all `ccff_tail` samples taken in the current or last load.

## Operation
- The FSM has three states: IDLE, LOAD, DONE.
- IDLE, on `start`:
  - go to LOAD
  - `bits_left` ← `CHAIN_LEN`
  - `tail_parity` ← 0
  - `done` ← 0
  - byte buffer marked empty
- LOAD:
  - The loader keeps a one-byte shift buffer and a bit index (0..`DATA_W`-1).
  - `data_ready` = buffer empty, OR (buffer holds its last valid bit AND that bit shifts this cycle). This gives gap-free throughput when `data_valid` is held high.
  - A handshake (`data_valid` && `data_ready`) loads the buffer and resets the bit index to 0.
  - Each cycle the buffer holds a bit: `ccff_head` ← buffer bit[index], `ccff_shift_en` ← 1, index++, `bits_left`--.
  - Each cycle the buffer is empty (upstream stall): `ccff_shift_en` ← 0 and `ccff_head` holds its value. No bit is lost or duplicated.
  - `tail_parity` ^= `ccff_tail` on every edge at which `ccff_shift_en`=1. This samples the value before the chain shifts on that gated edge.
  - When the last bit is issued (`bits_left` 1→0): go to DONE next cycle. The unused high bits of the final byte are discarded. `data_ready` is 0 from that cycle on, so no extra byte is consumed.
- DONE:
  - `done`=1, `busy`=0, `ccff_shift_en`=0.
  - The parity sample for the final shift is taken on entry to DONE.
  - `start` → LOAD, with the same initialisation as from IDLE.
- `busy` = (state == LOAD).
- `start` while in LOAD has no effect.
- `prog_reset` clears everything, from any state, including mid-load:
  - state → IDLE
  - `ccff_shift_en`, `ccff_head`, `data_ready`, `busy`, `done`, `tail_parity` all → 0
  - `bits_left` → 0
  - Chain contents after a reset mid-load are undefined; software must reload.

## Timing
- All outputs are registered. There are no combinational input-to-output paths except `data_ready`, which depends only on internal registers.
- `start` at edge N → `busy`=1 and `data_ready`=1 after edge N.
- A byte accepted at edge M puts its bit 0 on `ccff_head`, with `ccff_shift_en`=1, after edge M+1. The chain captures it on the gated edge M+2.
- With no stalls, a load takes `CHAIN_LEN`+2 cycles from `start` to `done`.
- Handshake rule: once `data_valid` is asserted, upstream holds it and `data_in` stable until accepted. `data_ready` may drop without a handshake only when LOAD ends.
- `bits_left` decrements in the same cycle that `ccff_shift_en` is issued and never underflows.

## Structure
- Shared package `ccff_pkg` holds:
  - the FSM state enum: `CCFF_IDLE`, `CCFF_LOAD`, `CCFF_DONE`
  - the default `CHAIN_LEN` and `DATA_W` constants shared with the fabric top
- One natural sub-module: `ccff_byte_serializer`, containing the buffer, bit index, `ready` logic, and serial output. The FSM, bit counter and parity stay in `ccff_loader`.
- The ICG is not inside this block; the fabric top instantiates it.

## Test plan
- **Basic load.** `CHAIN_LEN`=6, `DATA_W`=8. Start, then send 0xA5 with `data_valid` held.
  - `ccff_head` sequence is 1,0,1,0,0,1 with `ccff_shift_en` high for exactly 6 cycles.
  - `done`=1 at cycle 8.
  - The byte's high 2 bits are dropped, and only one handshake occurs.
- **Multi-byte and parity.** `CHAIN_LEN`=20, bytes 0xFF,0x00,0x0F.
  - 20 contiguous shifts with no bubble at byte boundaries.
  - The third byte's upper nibble is never shifted.
  - `tail_parity` equals the XOR of the 20 driven `ccff_tail` values.
- **Stall.** Deassert `data_valid` for 5 cycles between bytes.
  - `ccff_shift_en`=0 for those cycles, `ccff_head` stable, `bits_left` frozen.
  - The final chain contents equal the no-stall case.
- **Reset mid-load.** Assert `prog_reset` at bit 10 of 20.
  - Next cycle: all outputs are 0 and state is IDLE.
  - A fresh `start` then loads cleanly from `bits_left`=20.
- **Start while busy and reload from DONE.**
  - A `start` pulse during LOAD is ignored: shift count stays 20.
  - A `start` in DONE clears `done` and `tail_parity` and runs a second, identical load.
- **Golden chain model.** A reference 6-bit shift register (3 two-bit mux mems) clocked by the gated clock.
  - After the load it holds exactly the 6 bits sent.
  - The tail samples equal the prior contents in order.

Source files
------------

// File: rtl/ccff_pkg.sv
// Shared types and defaults for the configuration-chain (ccff) loader and fabric top.
package ccff_pkg;

  localparam int CCFF_CHAIN_LEN = 1024;
  localparam int CCFF_DATA_W    = 8;

  typedef enum logic [1:0] {
    CCFF_IDLE = 2'd0,
    CCFF_LOAD = 2'd1,
    CCFF_DONE = 2'd2
  } ccff_state_e;

  // Width of a bit index into a data_w-wide byte; never zero.
  function automatic int ccff_idx_w(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/ccff_loader_if.sv
// Configuration byte stream: valid/ready handshake from upstream into the loader.
interface ccff_loader_if #(
  parameter int DATA_W = ccff_pkg::CCFF_DATA_W
) ();

  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);

endinterface

// File: rtl/ccff_byte_serializer.sv
// One-byte buffer that walks its bits LSB-first onto the chain head.
module ccff_byte_serializer
  import ccff_pkg::*;
#(
  parameter int DATA_W = CCFF_DATA_W
) (
  input  logic         prog_clk,
  input  logic         prog_reset,
  input  logic         i_active,     // FSM is in LOAD
  input  logic         i_clear,      // a load is starting: drop any buffered byte
  input  logic         i_more_bits,  // chain still needs bits
  input  logic         i_last_bit,   // exactly one bit still needed
  ccff_loader_if.slave s_data,
  output logic         o_fire,       // a bit is issued at the coming edge
  output logic         o_head,
  output logic         o_shift_en
);

  localparam int              IDX_W    = ccff_idx_w(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic [DATA_W-1:0] r_buf;
  logic [IDX_W-1:0]  r_idx;
  logic              r_full;
  logic              r_head;
  logic              r_shift_en;
  logic              w_fire;
  logic              w_ready;
  logic              w_hs;

  // Issue decision and ready: refill early when the last buffered bit leaves,
  // but never ask for a byte once the final chain bit is on its way.
  // NOTE: every signal here is assigned on every path, so no latch is inferred.
  always_comb begin
    w_fire  = i_active && i_more_bits && r_full;
    w_ready = i_active && i_more_bits &&
              (!r_full || ((r_idx == LAST_IDX) && !i_last_bit));
    w_hs    = w_ready && s_data.data_valid;
  end

  // Buffer load, bit walk and registered serial output.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the byte buffer is a handful of flops, so it is reset like the rest
  // to keep the head bit and chain inputs deterministic after prog_reset.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_buf      <= '0;
      r_idx      <= '0;
      r_full     <= 1'b0;
      r_head     <= 1'b0;
      r_shift_en <= 1'b0;
    end else begin
      r_shift_en <= w_fire;
      if (w_fire) begin
        r_head <= r_buf[r_idx];
      end
      if (i_clear) begin
        r_full <= 1'b0;
        r_idx  <= '0;
      end else if (w_hs) begin
        r_buf  <= s_data.data_in;
        r_idx  <= '0;
        r_full <= 1'b1;
      end else if (w_fire) begin
        if (r_idx == LAST_IDX) begin
          r_full <= 1'b0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign s_data.data_ready = w_ready;
  assign o_fire            = w_fire;
  assign o_head            = r_head;
  assign o_shift_en        = r_shift_en;

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader: FSM, remaining-bit counter and tail parity signature.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter  int CHAIN_LEN = CCFF_CHAIN_LEN,
  parameter  int DATA_W    = CCFF_DATA_W,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic             prog_clk,
  input  logic             prog_reset,
  input  logic             start,
  ccff_loader_if.slave     s_data,
  output logic             ccff_head,
  output logic             ccff_shift_en,
  input  logic             ccff_tail,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bits_left,
  output logic             tail_parity
);

  ccff_state_e      r_state;
  logic [CNT_W-1:0] r_bits_left;
  logic             r_done;
  logic             r_parity;
  logic             w_active;
  logic             w_start;
  logic             w_more;
  logic             w_last;
  logic             w_fire;
  logic             w_head;
  logic             w_shift_en;

  // Decode of the current state and counter for the serializer.
  always_comb begin
    w_active = (r_state == CCFF_LOAD);
    w_start  = start && (r_state != CCFF_LOAD);
    w_more   = (r_bits_left != '0);
    w_last   = (r_bits_left == CNT_W'(1));
  end

  ccff_byte_serializer #(
    .DATA_W (DATA_W)
  ) u_ser (
    .prog_clk    (prog_clk),
    .prog_reset  (prog_reset),
    .i_active    (w_active),
    .i_clear     (w_start),
    .i_more_bits (w_more),
    .i_last_bit  (w_last),
    .s_data      (s_data),
    .o_fire      (w_fire),
    .o_head      (w_head),
    .o_shift_en  (w_shift_en)
  );

  // Load sequencing; LOAD lingers one cycle at zero bits so the final
  // gated edge is sampled into the parity as DONE is entered.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_state     <= CCFF_IDLE;
      r_bits_left <= '0;
      r_done      <= 1'b0;
      r_parity    <= 1'b0;
    end else begin
      if (w_shift_en) begin
        r_parity <= r_parity ^ ccff_tail;
      end
      case (r_state)
        CCFF_IDLE, CCFF_DONE: begin
          if (start) begin
            r_state     <= CCFF_LOAD;
            r_bits_left <= CNT_W'(CHAIN_LEN);
            r_parity    <= 1'b0;
            r_done      <= 1'b0;
          end
        end
        CCFF_LOAD: begin
          if (w_fire) begin
            r_bits_left <= r_bits_left - 1'b1;
          end
          if (!w_more) begin
            r_state <= CCFF_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= CCFF_IDLE;
      endcase
    end
  end

  assign ccff_head     = w_head;
  assign ccff_shift_en = w_shift_en;
  assign busy          = w_active;
  assign done          = r_done;
  assign bits_left     = r_bits_left;
  assign tail_parity   = r_parity;

endmodule

// File: tb/tb_ccff_loader.sv
// Self-checking bench for ccff_loader: a 6-bit and a 20-bit chain, each modelled
// as a plain shift register clocked whenever the loader enables the chain clock.
module tb_ccff_loader;

  localparam int DW  = 8;
  localparam int LA  = 6;
  localparam int LB  = 20;
  localparam int CWA = $clog2(LA + 1);
  localparam int CWB = $clog2(LB + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   total = 0;
  int   bad   = 0;

  // DUT A: 6-bit chain
  logic           start_a, head_a, sen_a, tail_a, busy_a, done_a, par_a;
  logic [CWA-1:0] bl_a;
  logic [LA-1:0]  chain_a;
  ccff_loader_if #(.DATA_W(DW)) ifa ();
  assign tail_a = chain_a[LA-1];

  ccff_loader #(.CHAIN_LEN(LA), .DATA_W(DW)) u_dut_a (
    .prog_clk      (clk),
    .prog_reset    (rst),
    .start         (start_a),
    .s_data        (ifa),
    .ccff_head     (head_a),
    .ccff_shift_en (sen_a),
    .ccff_tail     (tail_a),
    .busy          (busy_a),
    .done          (done_a),
    .bits_left     (bl_a),
    .tail_parity   (par_a)
  );

  // DUT B: 20-bit chain
  logic           start_b, head_b, sen_b, tail_b, busy_b, done_b, par_b;
  logic [CWB-1:0] bl_b;
  logic [LB-1:0]  chain_b;
  ccff_loader_if #(.DATA_W(DW)) ifb ();
  assign tail_b = chain_b[LB-1];

  ccff_loader #(.CHAIN_LEN(LB), .DATA_W(DW)) u_dut_b (
    .prog_clk      (clk),
    .prog_reset    (rst),
    .start         (start_b),
    .s_data        (ifb),
    .ccff_head     (head_b),
    .ccff_shift_en (sen_b),
    .ccff_tail     (tail_b),
    .busy          (busy_b),
    .done          (done_b),
    .bits_left     (bl_b),
    .tail_parity   (par_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // 6-bit chain: one byte 0xA5 with data_valid held for the whole load.
  task automatic load_a();
    logic [LA-1:0] prior, got_heads, got_tails, exp_heads, exp_chain, exp_tails;
    logic [7:0]    b;
    int            nshift, nhs, done_k;
    logic          pend, pend_head;
    b         = 8'hA5;
    prior     = LA'($urandom);
    chain_a   = prior;
    nshift    = 0;
    nhs       = 0;
    done_k    = -1;
    got_heads = '0;
    got_tails = '0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    ifa.data_valid = 1'b1;
    ifa.data_in    = b;
    for (int k = 0; k < 60; k++) begin
      if (done_a) begin
        done_k = k;
        break;
      end
      if (ifa.data_valid && ifa.data_ready) nhs++;
      pend      = sen_a;
      pend_head = head_a;
      if (sen_a) begin
        if (nshift < LA) begin
          got_heads[nshift] = head_a;
          got_tails[nshift] = tail_a;
        end
        nshift++;
      end
      @(posedge clk); #1;
      if (pend) chain_a = {chain_a[LA-2:0], pend_head};
    end
    ifa.data_valid = 1'b0;
    for (int i = 0; i < LA; i++) begin
      exp_heads[i]        = b[i];
      exp_chain[LA-1-i]   = b[i];
      exp_tails[i]        = prior[LA-1-i];
    end
    check("a_head_seq",    got_heads, exp_heads);
    check("a_shift_count", nshift, LA);
    check("a_done_cycle",  done_k, LA + 2);
    check("a_handshakes",  nhs, 1);
    check("a_chain",       chain_a, exp_chain);
    check("a_tail_order",  got_tails, exp_tails);
    check("a_parity",      par_a, ^prior);
    check("a_done_sen",    sen_a, 1'b0);
    check("a_done_busy",   busy_a, 1'b0);
  endtask

  // 20-bit chain load. stall_after < 0 means no forced stall; busy_start_at
  // pulses start during the load; reset_at > 0 aborts with prog_reset.
  task automatic load_b(input logic [7:0] bytes[$], input int stall_after, input int stall_len,
                        input bit rnd, input int busy_start_at, input int reset_at,
                        output logic [LB-1:0] final_chain);
    logic [LB-1:0]  prior, got_heads, got_tails, exp_heads, exp_chain, exp_tails;
    logic           exp_bits[$];
    int             nshift, nhs, bubbles, byte_i, stall_left, err_bl, err_hold, done_k;
    logic           hs, pend, pend_head, prev_head;
    logic [CWB-1:0] prev_bl;
    prior       = LB'($urandom);
    chain_b     = prior;
    final_chain = chain_b;
    nshift = 0; nhs = 0; bubbles = 0; byte_i = 0; stall_left = 0;
    err_bl = 0; err_hold = 0; done_k = -1;
    got_heads = '0; got_tails = '0;
    ifb.data_valid = 1'b0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    check("b_start_busy",      busy_b, 1'b1);
    check("b_start_bits_left", bl_b, LB);
    check("b_start_done_clr",  done_b, 1'b0);
    check("b_start_par_clr",   par_b, 1'b0);
    check("b_start_ready",     ifb.data_ready, 1'b1);
    prev_head = head_b;
    prev_bl   = bl_b;
    for (int k = 0; k < 400; k++) begin
      if (done_b) begin
        done_k = k;
        break;
      end
      if (!ifb.data_valid && byte_i < bytes.size()) begin
        if (stall_left > 0) begin
          if (ifb.data_ready) stall_left--;
        end else if (!(rnd && $urandom_range(0, 3) == 0)) begin
          ifb.data_valid = 1'b1;
          ifb.data_in    = bytes[byte_i];
        end
      end
      hs        = ifb.data_valid && ifb.data_ready;
      pend      = sen_b;
      pend_head = head_b;
      if (sen_b) begin
        if (nshift < LB) begin
          got_heads[nshift] = head_b;
          got_tails[nshift] = tail_b;
        end
        nshift++;
      end else if (busy_b && nshift > 0 && nshift < LB) begin
        bubbles++;
        if (head_b !== prev_head || bl_b !== prev_bl) err_hold++;
      end
      if (busy_b && bl_b !== CWB'(LB - nshift)) err_bl++;
      prev_head = head_b;
      prev_bl   = bl_b;
      if (reset_at > 0 && nshift == reset_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ifb.data_valid = 1'b0;
        check("b_rst_head",  head_b, 1'b0);
        check("b_rst_sen",   sen_b, 1'b0);
        check("b_rst_ready", ifb.data_ready, 1'b0);
        check("b_rst_busy",  busy_b, 1'b0);
        check("b_rst_done",  done_b, 1'b0);
        check("b_rst_par",   par_b, 1'b0);
        check("b_rst_bl",    bl_b, 0);
        final_chain = chain_b;
        return;
      end
      start_b = (k == busy_start_at);
      @(posedge clk); #1;
      start_b = 1'b0;
      if (pend) chain_b = {chain_b[LB-2:0], pend_head};
      if (hs) begin
        for (int i = 0; i < DW; i++) exp_bits.push_back(bytes[byte_i][i]);
        byte_i++;
        nhs++;
        ifb.data_valid = 1'b0;
        if (byte_i - 1 == stall_after) stall_left = stall_len;
      end
    end
    exp_heads = '0;
    exp_chain = '0;
    for (int i = 0; i < LB; i++) begin
      if (i < exp_bits.size()) begin
        exp_heads[i]      = exp_bits[i];
        exp_chain[LB-1-i] = exp_bits[i];
      end
      exp_tails[i] = prior[LB-1-i];
    end
    check("b_done_seen",    done_k >= 0, 1'b1);
    check("b_shift_count",  nshift, LB);
    check("b_handshakes",   nhs, (LB + DW - 1) / DW);
    check("b_head_stream",  got_heads, exp_heads);
    check("b_final_chain",  chain_b, exp_chain);
    check("b_tail_order",   got_tails, exp_tails);
    check("b_parity",       par_b, ^prior);
    check("b_bl_track",     err_bl, 0);
    check("b_stall_hold",   err_hold, 0);
    if (!rnd) begin
      check("b_bubbles", bubbles, (stall_after >= 0) ? stall_len : 0);
      check("b_latency", done_k, LB + 2 + ((stall_after >= 0) ? stall_len : 0));
    end
    check("b_done_busy",  busy_b, 1'b0);
    check("b_done_sen",   sen_b, 1'b0);
    check("b_done_bl",    bl_b, 0);
    check("b_done_ready", ifb.data_ready, 1'b0);
    final_chain = chain_b;
  endtask

  initial begin
    logic [7:0]    bytes[$];
    logic [LB-1:0] ch_ref, ch_stall, ch_tmp;
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    ifa.data_valid = 1'b0; ifa.data_in = '0;
    ifb.data_valid = 1'b0; ifb.data_in = '0;
    chain_a = '0; chain_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_outputs", {head_a, sen_a, busy_a, done_a, par_a, ifa.data_ready}, 6'b0);
    check("rst_a_bl",      bl_a, 0);
    check("rst_b_outputs", {head_b, sen_b, busy_b, done_b, par_b, ifb.data_ready}, 6'b0);
    check("rst_b_bl",      bl_b, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    load_a();

    bytes = '{8'hFF, 8'h00, 8'h0F};
    load_b(bytes, -1, 0, 1'b0, -1, 0, ch_ref);
    load_b(bytes, 0, 5, 1'b0, -1, 0, ch_stall);
    check("b_stall_chain_same", ch_stall, ch_ref);
    load_b(bytes, -1, 0, 1'b0, -1, 10, ch_tmp);
    load_b(bytes, -1, 0, 1'b0, 8, 0, ch_tmp);
    check("b_busy_start_chain", ch_tmp, ch_ref);
    load_b(bytes, -1, 0, 1'b0, -1, 0, ch_tmp);
    check("b_reload_chain", ch_tmp, ch_ref);

    for (int r = 0; r < 4; r++) begin
      bytes = '{};
      for (int j = 0; j < 3; j++) bytes.push_back(8'($urandom));
      load_b(bytes, -1, 0, 1'b1, -1, 0, ch_tmp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
